// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer:
// opcode/funct constants, control-field encodings, state type and the
// control-word record produced by the output decoder.
package mc_ctrl_pkg;

   // Opcode field values
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_BGEZ  = 6'b100111;
   localparam logic [5:0] OP_JPC   = 6'b011110;

   // Funct field values for R-type instructions with special sequencing
   localparam logic [5:0] FN_BALRN = 6'b010111;
   localparam logic [5:0] FN_JMADD = 6'b100001;

   // aluop encoding (shared with the single-cycle decoder)
   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_RTYPE = 3'b010;
   localparam logic [2:0] ALU_BGEZ  = 3'b011;
   localparam logic [2:0] ALU_OR    = 3'b100;

   // pc_source encoding
   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_MDR    = 2'b10;
   localparam logic [1:0] PCS_REGA   = 2'b11;

   // alusrcb encoding
   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   // branch encoding
   localparam logic [1:0] BR_NONE  = 2'b00;
   localparam logic [1:0] BR_BEQ   = 2'b01;
   localparam logic [1:0] BR_BGEZ  = 2'b10;
   localparam logic [1:0] BR_BALRN = 2'b11;

   // Sequencer states; FETCH is zero so the debug port reads 0 out of reset
   typedef enum logic [4:0] {
      S_FETCH    = 5'd0,
      S_DECODE   = 5'd1,
      S_MEM_ADDR = 5'd2,
      S_MEM_RD   = 5'd3,
      S_MEM_WB   = 5'd4,
      S_MEM_WR   = 5'd5,
      S_R_EXEC   = 5'd6,
      S_R_WB     = 5'd7,
      S_ORI_EXEC = 5'd8,
      S_ORI_WB   = 5'd9,
      S_BEQ      = 5'd10,
      S_BGEZ     = 5'd11,
      S_BALRN    = 5'd12,
      S_JPC      = 5'd13,
      S_JM_ADDR  = 5'd14,
      S_JM_RD    = 5'd15,
      S_JM_JMP   = 5'd16,
      S_TRAP     = 5'd17
   } state_e;

   // Per-state datapath control word
   typedef struct packed {
      logic       mem_req;
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [2:0] aluop;
      logic       regdest;
      logic       link31;
      logic       memtoreg;
      logic       regwrite;
      logic       statusregwrite;
      logic [1:0] branch;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> control-word decode for the multi-cycle sequencer.
// Only FETCH looks at mem_ready (IR and PC load on the completing cycle).
module mc_ctrl_outdec
   import mc_ctrl_pkg::*;
(
   input  state_e state,
   input  logic   mem_ready,
   output ctrl_t  ctrl
);

   // Decode the current state into datapath enables; unlisted fields stay 0
   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_req   = 1'b1;
            ctrl.mem_read  = 1'b1;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
            ctrl.alusrcb   = SRCB_FOUR;
            ctrl.aluop     = ALU_ADD;
            ctrl.pc_source = PCS_ALU;
         end
         S_DECODE: begin
            ctrl.alusrcb = SRCB_IMMSH;
            ctrl.aluop   = ALU_ADD;
         end
         S_MEM_ADDR: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_IMM;
            ctrl.aluop   = ALU_ADD;
         end
         S_MEM_RD, S_JM_RD: begin
            ctrl.mem_req  = 1'b1;
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.regwrite = 1'b1;
            ctrl.memtoreg = 1'b1;
         end
         S_MEM_WR: begin
            ctrl.mem_req   = 1'b1;
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
         end
         S_R_EXEC: begin
            ctrl.alusrca        = 1'b1;
            ctrl.alusrcb        = SRCB_REGB;
            ctrl.aluop          = ALU_RTYPE;
            ctrl.statusregwrite = 1'b1;
         end
         S_R_WB: begin
            ctrl.regwrite = 1'b1;
            ctrl.regdest  = 1'b1;
         end
         S_ORI_EXEC: begin
            ctrl.alusrca        = 1'b1;
            ctrl.alusrcb        = SRCB_IMM;
            ctrl.aluop          = ALU_OR;
            ctrl.statusregwrite = 1'b1;
         end
         S_ORI_WB: begin
            ctrl.regwrite = 1'b1;
         end
         S_BEQ: begin
            ctrl.alusrca       = 1'b1;
            ctrl.alusrcb       = SRCB_REGB;
            ctrl.aluop         = ALU_SUB;
            ctrl.branch        = BR_BEQ;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCS_ALUOUT;
         end
         S_BGEZ: begin
            ctrl.alusrca       = 1'b1;
            ctrl.alusrcb       = SRCB_REGB;
            ctrl.aluop         = ALU_BGEZ;
            ctrl.branch        = BR_BGEZ;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCS_ALUOUT;
         end
         S_BALRN: begin
            ctrl.branch        = BR_BALRN;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCS_REGA;
            ctrl.regwrite      = 1'b1;
            ctrl.regdest       = 1'b1;
         end
         S_JPC: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCS_ALUOUT;
            ctrl.regwrite  = 1'b1;
            ctrl.link31    = 1'b1;
         end
         S_JM_ADDR: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_REGB;
            ctrl.aluop   = ALU_ADD;
         end
         S_JM_JMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCS_MDR;
            ctrl.regwrite  = 1'b1;
            ctrl.link31    = 1'b1;
         end
         S_TRAP: begin
            ctrl.illegal = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer: next-state logic, memory wait counter
// with timeout pulse, and output gating. Control word comes from
// mc_ctrl_outdec.
// Optional: define MULTICYCLE_CTRL_TRAP_EN to send undefined opcodes to a
// sticky TRAP state that raises illegal until reset.
module multicycle_control
   import mc_ctrl_pkg::*;
#(
   parameter int OPW      = 6,
   parameter int WAIT_MAX = 15
)
(
   input  logic           clk,
   input  logic           reset,
   input  logic [OPW-1:0] opcode,
   input  logic [OPW-1:0] funct,
   input  logic           zero,
   input  logic           status_n,
   input  logic           mem_ready,
   output logic           mem_req,
   output logic           mem_read,
   output logic           mem_write,
   output logic           iord,
   output logic           ir_write,
   output logic           pc_write,
   output logic           pc_write_cond,
   output logic [1:0]     pc_source,
   output logic           alusrca,
   output logic [1:0]     alusrcb,
   output logic [2:0]     aluop,
   output logic           regdest,
   output logic           link31,
   output logic           memtoreg,
   output logic           regwrite,
   output logic           statusregwrite,
   output logic [1:0]     branch,
   output logic           illegal,
   output logic           mem_timeout,
   output logic [4:0]     state_o
);

   localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] WMAX  = CW'(WAIT_MAX);
   localparam logic [CW-1:0] WLAST = CW'((WAIT_MAX == 0) ? 0 : WAIT_MAX - 1);

   state_e        state;
   state_e        state_nx;
   ctrl_t         ctrl;
   ctrl_t         ctrl_g;
   logic [CW-1:0] wcnt;
   logic          waiting;
   logic          unused;

   mc_ctrl_outdec u_outdec (
      .state     (state),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );

   // Next-state selection; memory states hold until mem_ready
   always_comb begin
      state_nx = state;
      case (state)
         S_FETCH:    if (mem_ready) state_nx = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_nx = S_MEM_ADDR;
               OP_RTYPE: begin
                  if (funct == FN_BALRN)      state_nx = S_BALRN;
                  else if (funct == FN_JMADD) state_nx = S_JM_ADDR;
                  else                        state_nx = S_R_EXEC;
               end
               OP_BEQ:  state_nx = S_BEQ;
               OP_BGEZ: state_nx = S_BGEZ;
               OP_ORI:  state_nx = S_ORI_EXEC;
               OP_JPC:  state_nx = S_JPC;
`ifdef MULTICYCLE_CTRL_TRAP_EN
               default: state_nx = S_TRAP;
`else
               default: state_nx = S_FETCH;
`endif
            endcase
         end
         S_MEM_ADDR: state_nx = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (mem_ready) state_nx = S_MEM_WB;
         S_MEM_WR:   if (mem_ready) state_nx = S_FETCH;
         S_R_EXEC:   state_nx = S_R_WB;
         S_ORI_EXEC: state_nx = S_ORI_WB;
         S_JM_ADDR:  state_nx = S_JM_RD;
         S_JM_RD:    if (mem_ready) state_nx = S_JM_JMP;
         S_MEM_WB, S_R_WB, S_ORI_WB, S_BEQ, S_BGEZ,
         S_BALRN, S_JPC, S_JM_JMP: state_nx = S_FETCH;
         S_TRAP:     state_nx = S_TRAP;
         default:    state_nx = S_FETCH;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= state_nx;
   end

   assign waiting = ctrl.mem_req & ~mem_ready;

   // Wait counter: counts stalled memory cycles, saturates at WAIT_MAX.
   // Every memory state exits only on mem_ready, so clearing on
   // "not waiting" also covers leaving the state.
   always_ff @(posedge clk) begin
      if (reset || !waiting)                  wcnt <= '0;
      else if (WAIT_MAX != 0 && wcnt != WMAX) wcnt <= wcnt + 1'b1;
   end

   // Outputs are forced low while reset is held, so an aborted instruction
   // cannot write the register file or PC in the reset cycle.
   assign ctrl_g = reset ? '0 : ctrl;

   assign mem_req        = ctrl_g.mem_req;
   assign mem_read       = ctrl_g.mem_read;
   assign mem_write      = ctrl_g.mem_write;
   assign iord           = ctrl_g.iord;
   assign ir_write       = ctrl_g.ir_write;
   assign pc_write       = ctrl_g.pc_write;
   assign pc_write_cond  = ctrl_g.pc_write_cond;
   assign pc_source      = ctrl_g.pc_source;
   assign alusrca        = ctrl_g.alusrca;
   assign alusrcb        = ctrl_g.alusrcb;
   assign aluop          = ctrl_g.aluop;
   assign regdest        = ctrl_g.regdest;
   assign link31         = ctrl_g.link31;
   assign memtoreg       = ctrl_g.memtoreg;
   assign regwrite       = ctrl_g.regwrite;
   assign statusregwrite = ctrl_g.statusregwrite;
   assign branch         = ctrl_g.branch;
   assign state_o        = reset ? 5'd0 : state;

   // Pulse in the stalled cycle that brings the counter to WAIT_MAX
   assign mem_timeout = ~reset & (WAIT_MAX != 0) & waiting & (wcnt == WLAST);

`ifdef MULTICYCLE_CTRL_TRAP_EN
   assign illegal = ctrl_g.illegal;
   assign unused  = ^{zero, status_n};
`else
   assign illegal = 1'b0;
   assign unused  = ^{zero, status_n, ctrl_g.illegal};
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed instructions followed
// by randomized instruction/wait streams checked against a per-instruction
// state-sequence model.
module tb_multicycle_control;
   import mc_ctrl_pkg::*;

   localparam int WMAX = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode, funct;
   logic       zero, status_n, mem_ready;
   logic       mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
   logic [1:0] pc_source, alusrcb, branch;
   logic       alusrca, regdest, link31, memtoreg, regwrite, statusregwrite;
   logic [2:0] aluop;
   logic       illegal, mem_timeout;
   logic [4:0] state_o;

   typedef struct packed {
      logic       mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
      logic [1:0] pc_source;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [2:0] aluop;
      logic       regdest, link31, memtoreg, regwrite, statusregwrite;
      logic [1:0] branch;
      logic       illegal, mem_timeout;
   } cw_t;

   cw_t    act;
   int     checks = 0;
   int     errors = 0;
   state_e seq[$];

   multicycle_control #(.OPW(6), .WAIT_MAX(WMAX)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .status_n(status_n), .mem_ready(mem_ready), .mem_req(mem_req),
      .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
      .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .pc_source(pc_source), .alusrca(alusrca), .alusrcb(alusrcb),
      .aluop(aluop), .regdest(regdest), .link31(link31), .memtoreg(memtoreg),
      .regwrite(regwrite), .statusregwrite(statusregwrite), .branch(branch),
      .illegal(illegal), .mem_timeout(mem_timeout), .state_o(state_o)
   );

   always #5 clk = ~clk;

   assign act = {mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
                 pc_source, alusrca, alusrcb, aluop, regdest, link31, memtoreg,
                 regwrite, statusregwrite, branch, illegal, mem_timeout};

   // Control word each state must present, transcribed from the state table
   function automatic cw_t exp_cw(input state_e s, input logic rdy, input logic tmo);
      cw_t e;
      e = '0;
      e.mem_timeout = tmo;
      case (s)
         S_FETCH:    begin e.mem_req = 1; e.mem_read = 1; e.ir_write = rdy;
                           e.pc_write = rdy; e.alusrcb = 2'b01; end
         S_DECODE:   e.alusrcb = 2'b11;
         S_MEM_ADDR: begin e.alusrca = 1; e.alusrcb = 2'b10; end
         S_MEM_RD:   begin e.mem_req = 1; e.mem_read = 1; e.iord = 1; end
         S_MEM_WB:   begin e.regwrite = 1; e.memtoreg = 1; end
         S_MEM_WR:   begin e.mem_req = 1; e.mem_write = 1; e.iord = 1; end
         S_R_EXEC:   begin e.alusrca = 1; e.aluop = 3'b010; e.statusregwrite = 1; end
         S_R_WB:     begin e.regwrite = 1; e.regdest = 1; end
         S_ORI_EXEC: begin e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = 3'b100;
                           e.statusregwrite = 1; end
         S_ORI_WB:   e.regwrite = 1;
         S_BEQ:      begin e.aluop = 3'b001; e.alusrca = 1; e.branch = 2'b01;
                           e.pc_write_cond = 1; e.pc_source = 2'b01; end
         S_BGEZ:     begin e.aluop = 3'b011; e.alusrca = 1; e.branch = 2'b10;
                           e.pc_write_cond = 1; e.pc_source = 2'b01; end
         S_BALRN:    begin e.branch = 2'b11; e.pc_write_cond = 1; e.pc_source = 2'b11;
                           e.regwrite = 1; e.regdest = 1; end
         S_JPC:      begin e.pc_write = 1; e.pc_source = 2'b01; e.regwrite = 1;
                           e.link31 = 1; end
         S_JM_ADDR:  e.alusrca = 1;
         S_JM_RD:    begin e.mem_req = 1; e.mem_read = 1; e.iord = 1; end
         S_JM_JMP:   begin e.pc_write = 1; e.pc_source = 2'b10; e.regwrite = 1;
                           e.link31 = 1; end
         S_TRAP:     e.illegal = 1;
         default:    e = '0;
      endcase
      return e;
   endfunction

   function automatic logic is_mem(input state_e s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR) || (s == S_JM_RD);
   endfunction

   // State path an instruction takes, straight from the instruction list
   task automatic build_seq(input logic [5:0] op, input logic [5:0] fn);
      seq.delete();
      seq.push_back(S_FETCH);
      seq.push_back(S_DECODE);
      case (op)
         6'b100011: begin seq.push_back(S_MEM_ADDR); seq.push_back(S_MEM_RD);
                          seq.push_back(S_MEM_WB); end
         6'b101011: begin seq.push_back(S_MEM_ADDR); seq.push_back(S_MEM_WR); end
         6'b000000: begin
            if (fn == 6'b010111) seq.push_back(S_BALRN);
            else if (fn == 6'b100001) begin
               seq.push_back(S_JM_ADDR); seq.push_back(S_JM_RD); seq.push_back(S_JM_JMP);
            end else begin
               seq.push_back(S_R_EXEC); seq.push_back(S_R_WB);
            end
         end
         6'b001101: begin seq.push_back(S_ORI_EXEC); seq.push_back(S_ORI_WB); end
         6'b000100: seq.push_back(S_BEQ);
         6'b100111: seq.push_back(S_BGEZ);
         6'b011110: seq.push_back(S_JPC);
`ifdef MULTICYCLE_CTRL_TRAP_EN
         default:   seq.push_back(S_TRAP);
`else
         default:   ;
`endif
      endcase
   endtask

   task automatic check(input string tag, input state_e s, input logic rdy, input logic tmo);
      cw_t e;
      e = exp_cw(s, rdy, tmo);
      checks++;
      assert (state_o === s) else begin
         errors++;
         $error("FAIL %s state: observed %0d expected %0d", tag, state_o, s);
      end
      checks++;
      assert (act === e) else begin
         errors++;
         $error("FAIL %s ctrl: observed %h expected %h", tag, act, e);
      end
   endtask

   task automatic check_zero(input string tag);
      checks++;
      assert (act === '0 && state_o === 5'd0) else begin
         errors++;
         $error("FAIL %s reset-zero: observed %h/%0d expected 0/0", tag, act, state_o);
      end
   endtask

   // One clock in state s: drive mem_ready, check mid-cycle, advance
   task automatic step(input string tag, input state_e s, input logic rdy, input logic tmo);
      mem_ready = rdy;
      #1;
      check(tag, s, rdy, tmo);
      @(posedge clk); #1;
   endtask

   // Run one instruction; fw/dw = wait cycles in FETCH / data access, -1 = random
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int fw, input int dw);
      int    w;
      string tag;
      build_seq(op, fn);
      opcode = op;
      funct  = fn;
      foreach (seq[i]) begin
         tag = $sformatf("op%b_fn%b_ph%0d", op, fn, i);
         if (is_mem(seq[i])) begin
            w = (seq[i] == S_FETCH) ? fw : dw;
            if (w < 0) w = int'($urandom_range(0, 4));
            for (int k = 0; k <= w; k++)
               step(tag, seq[i], (k == w), (k < w) && (k == WMAX - 1));
         end else begin
            step(tag, seq[i], 1'($urandom_range(0, 1)), 1'b0);
         end
      end
   endtask

   logic [5:0] ops [10] = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000000,
                            6'b001101, 6'b000100, 6'b100111, 6'b011110, 6'b111111};

   initial begin
      logic [5:0] op, fn;
      reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; status_n = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      mem_ready = 1'b1;
      #1;
      check_zero("reset_rdy");
      @(posedge clk); #1;
      reset = 1'b0;

      // Directed instructions
      run_instr(6'b100011, 6'b000000, 0, 0);   // lw
      run_instr(6'b101011, 6'b000000, 0, 3);   // sw, 3 stall cycles
      run_instr(6'b000100, 6'b000000, 0, 0);   // beq
      run_instr(6'b100111, 6'b000000, 0, 0);   // bgez
      run_instr(6'b000000, 6'b010111, 0, 0);   // balrn
      run_instr(6'b000000, 6'b100001, 0, 0);   // jmadd
      run_instr(6'b000000, 6'b100000, 0, 0);   // R-type add
      run_instr(6'b001101, 6'b000000, 0, 0);   // ori
      run_instr(6'b011110, 6'b000000, 0, 0);   // jpc
      run_instr(6'b000000, 6'b100001, 2, 4);   // jmadd with stalls and timeout
`ifndef MULTICYCLE_CTRL_TRAP_EN
      run_instr(6'b111111, 6'b000000, 0, 0);   // undefined opcode -> FETCH
`endif

      // FETCH stuck: single timeout pulse on 3rd stalled cycle, then reset
      opcode = 6'b000000; funct = 6'b100000;
      for (int k = 0; k < 6; k++)
         step("fetch_stuck", S_FETCH, 1'b0, (k == WMAX - 1));
      reset = 1'b1;
      #1;
      check_zero("reset_after_stuck");
      @(posedge clk); #1;
      reset = 1'b0;

      // Reset in R_WB: no register write that cycle, restart in FETCH
      opcode = 6'b000000; funct = 6'b100000;
      step("abort_f", S_FETCH, 1'b1, 1'b0);
      step("abort_d", S_DECODE, 1'b0, 1'b0);
      step("abort_x", S_R_EXEC, 1'b0, 1'b0);
      reset = 1'b1;
      #1;
      check_zero("abort_wb");
      @(posedge clk); #1;
      reset = 1'b0;

      // Randomized instruction stream
      for (int n = 0; n < 80; n++) begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
         op = ops[$urandom_range(0, 8)];
`else
         op = ops[$urandom_range(0, 9)];
`endif
         case ($urandom_range(0, 2))
            0:       fn = 6'b010111;
            1:       fn = 6'b100001;
            default: fn = 6'($urandom_range(0, 63));
         endcase
         run_instr(op, fn, -1, -1);
      end

`ifdef MULTICYCLE_CTRL_TRAP_EN
      // Undefined opcode traps and holds until reset
      run_instr(6'b111111, 6'b000000, 0, 0);
      for (int k = 0; k < 3; k++)
         step("trap_hold", S_TRAP, 1'($urandom_range(0, 1)), 1'b0);
      reset = 1'b1;
      #1;
      check_zero("trap_reset");
      @(posedge clk); #1;
      reset = 1'b0;
      run_instr(6'b100011, 6'b000000, 0, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
